// File: rtl/exec_stage_mc_if.sv
// -----------------------------------------------------------------------------
// exec_stage_mc_if
// Bundle between the decode register, the execute stage and the memory stage.
//   Decode side    : inValid, op, a, b, brType, pc, offset, writeReg, regWrt
//   Control        : flushPipe (squash from a later stage), memStall (back-pressure)
//   Execute result : stallOut, outValid, result, writeRegOut, regWrtOut,
//                    doBranch, branchPc, divZero, err
// master : the side that drives instructions and control (decode/memory)
// slave  : the execute stage itself
// -----------------------------------------------------------------------------
interface exec_stage_mc_if #(
  parameter int WIDTH = 16
);
  logic             inValid;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       brType;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] offset;
  logic [2:0]       writeReg;
  logic             regWrt;
  logic             flushPipe;
  logic             memStall;

  logic             stallOut;
  logic             outValid;
  logic [WIDTH-1:0] result;
  logic [2:0]       writeRegOut;
  logic             regWrtOut;
  logic             doBranch;
  logic [WIDTH-1:0] branchPc;
  logic             divZero;
  logic             err;

  modport master (
    output inValid, op, a, b, brType, pc, offset, writeReg, regWrt,
           flushPipe, memStall,
    input  stallOut, outValid, result, writeRegOut, regWrtOut, doBranch,
           branchPc, divZero, err
  );

  modport slave (
    input  inValid, op, a, b, brType, pc, offset, writeReg, regWrt,
           flushPipe, memStall,
    output stallOut, outValid, result, writeRegOut, regWrtOut, doBranch,
           branchPc, divZero, err
  );
endinterface

// File: rtl/exec_stage_mc.sv
// -----------------------------------------------------------------------------
// exec_stage_mc
// Execute stage: single-cycle ALU (ADD/SUB/AND/XOR/SLT), an iterative
// multiply/divide unit (MUL, DIVU, REMU; one step per cycle, WIDTH steps),
// branch resolution, and an output register toward the memory stage.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - exec_stage_mc_if.slave (instruction in, result out, flush/stall)
// -----------------------------------------------------------------------------
module exec_stage_mc #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  exec_stage_mc_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0]       OP_MUL    = 3'd5;
  localparam logic [2:0]       OP_DIVU   = 3'd6;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  // Fields that travel with an instruction independently of its result.
  typedef struct packed {
    logic [2:0]       wreg;
    logic             regwrt;
    logic             dobr;
    logic [WIDTH-1:0] bpc;
    logic             err;
  } meta_t;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] result;
    logic             divzero;
    meta_t            meta;
  } out_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  out_t             out_q, out_d;

  // Iterative unit registers.
  // MUL : acc = partial product, opa = multiplicand (shifts left),
  //       opb = multiplier (shifts right).
  // DIV : acc = partial remainder, opa = dividend shifting out / quotient
  //       shifting in, opb = divisor (static).
  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  meta_t            pend_q;

  logic             stall;
  logic             accept;
  logic             is_mc;
  logic             br_taken;
  logic             br_err;
  logic [WIDTH-1:0] alu_res;
  meta_t            entry_meta;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [WIDTH-1:0] done_result;
  logic             done_dz;

  assign stall  = (state_q != IDLE) | bus.memStall;
  assign is_mc  = bus.op[2] & (bus.op[1] | bus.op[0]);
  // The last term drops the wrong-path instruction behind a taken branch.
  assign accept = bus.inValid & ~stall & ~bus.flushPipe
                & ~(out_q.valid & out_q.meta.dobr);

  // Branch resolution on the incoming instruction.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    br_taken = 1'b0;
    br_err   = 1'b0;
    case (bus.brType)
      3'd0:    br_taken = 1'b0;
      3'd1:    br_taken = (bus.a == '0);
      3'd2:    br_taken = (bus.a != '0);
      3'd3:    br_taken = bus.a[WIDTH-1];
      3'd4:    br_taken = ~bus.a[WIDTH-1];
      default: br_err   = 1'b1;
    endcase
  end

  always_comb begin
    entry_meta.wreg   = bus.writeReg;
    entry_meta.regwrt = bus.regWrt;
    entry_meta.dobr   = br_taken;
    entry_meta.bpc    = bus.pc + bus.offset;
    entry_meta.err    = br_err;
  end

  // Single-cycle ALU.
  always_comb begin
    alu_res = '0;
    case (bus.op)
      3'd0:    alu_res = bus.a + bus.b;
      3'd1:    alu_res = bus.a - bus.b;
      3'd2:    alu_res = bus.a & bus.b;
      3'd3:    alu_res = bus.a ^ bus.b;
      3'd4:    alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      default: alu_res = '0;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    rem_shift = {acc_q, opa_q[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, opb_q};
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    if (op_q == OP_MUL) begin
      acc_d = opb_q[0] ? acc_q + opa_q : acc_q;
      opa_d = opa_q << 1;
      opb_d = opb_q >> 1;
    end else begin
      // A zero divisor always "fits", so the quotient comes out all-ones and
      // the remainder ends up equal to the dividend with no special case.
      acc_d = rem_ge ? WIDTH'(rem_shift - {1'b0, opb_q}) : rem_shift[WIDTH-1:0];
      opa_d = {opa_q[WIDTH-2:0], rem_ge};
    end
  end

  assign done_result = (op_q == OP_DIVU) ? opa_q : acc_q;
  assign done_dz     = (op_q != OP_MUL) && (opb_q == '0);

  // Next output register contents when not stalled: a completed long op, a
  // freshly accepted single-cycle op, or a bubble.
  always_comb begin
    out_d = '0;
    if (state_q == DONE) begin
      out_d.valid   = 1'b1;
      out_d.result  = done_result;
      out_d.divzero = done_dz;
      out_d.meta    = pend_q;
    end else if (accept && !is_mc) begin
      out_d.valid  = 1'b1;
      out_d.result = alu_res;
      out_d.meta   = entry_meta;
    end
  end

  // Control FSM and output register. Flush shares the reset path: it abandons
  // any in-flight long op and clears the outputs at the same edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst || bus.flushPipe) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept && is_mc) begin
          state_q <= BUSY;
          cnt_q   <= '0;
        end
        BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) state_q <= DONE;
        end
        DONE: if (!bus.memStall) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (!bus.memStall) out_q <= out_d;
    end
  end

  // NOTE: the iterative datapath is not reset; it is always loaded on accept
  // before being read, and leaving it out of reset keeps the reset net small.
  always_ff @(posedge clk) begin
    if (accept && is_mc) begin
      op_q   <= bus.op;
      opa_q  <= bus.a;
      opb_q  <= bus.b;
      acc_q  <= '0;
      pend_q <= entry_meta;
    end else if (state_q == BUSY) begin
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
    end
  end

  assign bus.stallOut    = stall;
  assign bus.outValid    = out_q.valid;
  assign bus.result      = out_q.result;
  assign bus.writeRegOut = out_q.meta.wreg;
  assign bus.regWrtOut   = out_q.meta.regwrt;
  assign bus.doBranch    = out_q.meta.dobr;
  assign bus.branchPc    = out_q.meta.bpc;
  assign bus.divZero     = out_q.divzero;
  assign bus.err         = out_q.meta.err;

endmodule
